// File: rtl/game_pkg.sv
`default_nettype none
// ============================================================================
// game_pkg : shared state encoding and layer constants for the frame sequencer
// Revision : 1.0
// ============================================================================
package game_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ARMED  = 3'd1,
    ST_UPDATE = 3'd2,
    ST_CLEAR  = 3'd3,
    ST_DRAW   = 3'd4,
    ST_WAIT   = 3'd5,
    ST_PAUSED = 3'd6,
    ST_END    = 3'd7
  } state_t;

  localparam int LAYER_SQUARES = 0;
  localparam int LAYER_CATCHER = 1;
  localparam int LAYER_SCORE   = 2;

  localparam int FRAME_DELAY_DEFAULT = 833333;

  // A single layer still needs a one-bit index register.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/frame_delay_counter.sv
`default_nettype none
// ============================================================================
// frame_delay_counter : loadable down-counter with zero flag, stops at zero
// Revision : 1.0
// ============================================================================
module frame_delay_counter #(
  parameter int WIDTH = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic             enable,
  input  logic [WIDTH-1:0] load_value,
  output logic             zero
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= load_value;
    end else if (enable && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign zero = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/game_frame_sequencer.sv
`default_nettype none
// ============================================================================
// game_frame_sequencer : start/update/clear/draw/wait frame FSM with pause,
//                        restart from game over and a frame counter
// Revision : 1.0
// ============================================================================
module game_frame_sequencer
  import game_pkg::*;
#(
  parameter int NUM_LAYERS  = 3,
  parameter int FRAME_DELAY = FRAME_DELAY_DEFAULT,
  parameter int CLEAR_EN    = 0,
  parameter int FRAME_W     = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  pause,
  input  logic                  finish_game,
  input  logic                  clear_done,
  input  logic [NUM_LAYERS-1:0] layer_done,
  output logic                  update,
  output logic                  clear_screen,
  output logic                  plot,
  output logic [NUM_LAYERS-1:0] layer_sel,
  output logic                  frame_tick,
  output logic                  paused,
  output logic                  game_over,
  output logic [FRAME_W-1:0]    frame_count
);

  localparam int c_idx_w = idx_width(NUM_LAYERS);
  localparam int c_cnt_w = $clog2(FRAME_DELAY);
  localparam logic [c_idx_w-1:0] c_last_idx  = c_idx_w'(NUM_LAYERS - 1);
  localparam logic [c_cnt_w-1:0] c_delay_ld  = c_cnt_w'(FRAME_DELAY - 1);

  state_t               r_state, w_next_state;
  logic [c_idx_w-1:0]   r_idx, w_idx_next;
  logic [FRAME_W-1:0]   r_frame_count;
  logic                 w_load;
  logic                 w_zero;

  frame_delay_counter #(.WIDTH(c_cnt_w)) u_delay (
    .clock      (clock),
    .reset      (reset),
    .load       (w_load),
    .enable     (r_state == ST_WAIT),
    .load_value (c_delay_ld),
    .zero       (w_zero)
  );

  always_comb begin
    w_next_state = r_state;
    w_idx_next   = r_idx;
    w_load       = 1'b0;
    case (r_state)
      ST_IDLE:   if (start) w_next_state = ST_ARMED;
      ST_ARMED:  if (!start) w_next_state = ST_UPDATE;
      ST_UPDATE: begin
        w_idx_next = '0;
        if (finish_game)        w_next_state = ST_END;
        else if (CLEAR_EN != 0) w_next_state = ST_CLEAR;
        else                    w_next_state = ST_DRAW;
      end
      ST_CLEAR: begin
        if (clear_done) begin
          w_next_state = ST_DRAW;
          w_idx_next   = '0;
        end
      end
      // Only the current layer's done bit matters; pause/finish wait for WAIT.
      ST_DRAW: begin
        if (layer_done[r_idx]) begin
          if (r_idx == c_last_idx) begin
            w_next_state = ST_WAIT;
            w_load       = 1'b1;
          end else begin
            w_idx_next = r_idx + 1'b1;
          end
        end
      end
      ST_WAIT:   if (w_zero) w_next_state = pause ? ST_PAUSED : ST_UPDATE;
      ST_PAUSED: if (!pause) w_next_state = ST_UPDATE;
      ST_END:    if (start) w_next_state = ST_ARMED;
      default:   w_next_state = ST_IDLE;
    endcase
  end

  // Clearing on entry to ARMED makes the restarted game read zero while armed.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_idx         <= '0;
      r_frame_count <= '0;
    end else begin
      r_state <= w_next_state;
      r_idx   <= w_idx_next;
      if (w_next_state == ST_ARMED) begin
        r_frame_count <= '0;
      end else if ((r_state == ST_WAIT) && w_zero) begin
        r_frame_count <= r_frame_count + 1'b1;
      end
    end
  end

  assign update       = (r_state == ST_UPDATE);
  assign clear_screen = (r_state == ST_CLEAR);
  assign plot         = (r_state == ST_CLEAR) || (r_state == ST_DRAW);
  assign layer_sel    = (r_state == ST_DRAW) ? (NUM_LAYERS'(1) << r_idx) : '0;
  assign frame_tick   = (r_state == ST_WAIT) && w_zero;
  assign paused       = (r_state == ST_PAUSED);
  assign game_over    = (r_state == ST_END);
  assign frame_count  = r_frame_count;

endmodule
`default_nettype wire
